// File: rtl/led_pwm_blink_if.sv
// led_pwm_blink_if: Avalon-MM slave bus for the LED PWM/blink configuration registers
interface led_pwm_blink_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/led_pwm_blink.sv
// led_pwm_blink: global PWM brightness and per-LED blinking applied to the PIO LED pattern
module led_pwm_blink #(
  parameter int WIDTH = 8,
  parameter int PRESCALE_BITS = 16,
  parameter int BLINK_BITS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] led_in,
  led_pwm_blink_if.slave   bus,
  output logic [WIDTH-1:0] led_out
);
  logic [7:0] shadow_bright, active_bright, pwm_cnt;
  logic pending, phase;
  logic [WIDTH-1:0] blink_mask;
  logic [BLINK_BITS-1:0] blink_half, blink_cnt;
  logic [PRESCALE_BITS-1:0] prescale, presc_cnt;
  logic wr, wr_bright, wr_mask, wr_half, wr_presc;
  logic tick, period_end, pwm_on, phase_on, blink_off, blink_wrap;
  assign wr = bus.chipselect & ~bus.write_n;
  assign wr_bright = wr && bus.address == 2'd0;
  assign wr_mask = wr && bus.address == 2'd1;
  assign wr_half = wr && bus.address == 2'd2;
  assign wr_presc = wr && bus.address == 2'd3;
  assign tick = presc_cnt == prescale;
  assign period_end = tick && pwm_cnt == 8'hFF;
  assign pwm_on = active_bright == 8'hFF || pwm_cnt < active_bright;
  assign blink_off = blink_half == '0;
  assign blink_wrap = blink_cnt == blink_half - BLINK_BITS'(1);
  // A zero half-period disables blinking immediately, without waiting for phase to resettle
  assign phase_on = phase | blink_off;
  // Zero-wait-state register readback
  always_comb begin
    bus.readdata = bus.address == 2'd0 ? {23'b0, pending, shadow_bright} :
                   bus.address == 2'd1 ? 32'(blink_mask) :
                   bus.address == 2'd2 ? 32'(blink_half) : 32'(prescale);
  end
  // Configuration registers; brightness is double-buffered and only taken at period boundaries
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_bright <= 8'hFF;
      active_bright <= 8'hFF;
      pending <= 1'b0;
      blink_mask <= '0;
      blink_half <= '0;
      prescale <= '0;
    end else begin
      if (wr_bright) shadow_bright <= bus.writedata[7:0];
      if (wr_mask) blink_mask <= bus.writedata[WIDTH-1:0];
      if (wr_half) blink_half <= bus.writedata[BLINK_BITS-1:0];
      if (wr_presc) prescale <= bus.writedata[PRESCALE_BITS-1:0];
      if (period_end && pending) active_bright <= shadow_bright;
      pending <= wr_bright | (pending & ~period_end);
    end
  end
  // Timebase: tick prescaler, PWM ramp and blink phase counted in PWM periods
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt <= '0;
      pwm_cnt <= '0;
      blink_cnt <= '0;
      phase <= 1'b1;
    end else begin
      presc_cnt <= (wr_presc || tick) ? '0 : presc_cnt + PRESCALE_BITS'(1);
      pwm_cnt <= tick ? pwm_cnt + 8'd1 : pwm_cnt;
      blink_cnt <= (blink_off || wr_half) ? '0 :
                   period_end ? (blink_wrap ? '0 : blink_cnt + BLINK_BITS'(1)) : blink_cnt;
      phase <= blink_off ? 1'b1 : (period_end && blink_wrap) ? ~phase : phase;
    end
  end
  // Registered LED drive
  always_ff @(posedge clk) begin
    if (reset) led_out <= '0;
    else led_out <= led_in & {WIDTH{pwm_on}} & (~blink_mask | {WIDTH{phase_on}});
  end
endmodule

// File: doc/led_pwm_blink.md
Name: led_pwm_blink

Overview:
- Downstream stage of the 8-bit LED output PIO: consumes the PIO's registered LED pattern and produces the physical LED drive.
- Adds global brightness via PWM and per-LED blinking.
- Configured through its own small Avalon-MM slave with the same 2-bit address, 32-bit data and zero-wait-state read style as the PIO.
- Software that only writes the PIO sees unchanged LED behaviour after reset.

Parameters:
- WIDTH, 8, number of LED lines.
- PRESCALE_BITS, 16, width of the PWM tick prescaler.
- BLINK_BITS, 16, width of the blink half-period register.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- led_in  in  WIDTH  LED pattern from the upstream PIO out_port.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  combinational read data, zero wait states.
- led_out  out  WIDTH  registered LED drive.

Behaviour:
- Registers:
  - addr0 BRIGHT: write [7:0] sets shadow_bright and pending=1. Read returns {23'b0, pending, shadow_bright}.
  - addr1 BLINK_MASK: [WIDTH-1:0], read/write.
  - addr2 BLINK_HALF: [BLINK_BITS-1:0], read/write.
  - addr3 PRESCALE: [PRESCALE_BITS-1:0], read/write.
  - Unused read bits are 0.
- A write occurs when chipselect=1 and write_n=0. Reads have no side effects.
- Reset values:
  - led_out=0, shadow_bright=255, active_bright=255, pending=0.
  - blink_mask=0, blink_half=0, prescale=0.
  - presc_cnt=0, pwm_cnt=0, blink_cnt=0, phase=1.
- Prescaler:
  - presc_cnt counts 0..prescale. tick=1 in the cycle where presc_cnt==prescale, then presc_cnt wraps to 0.
  - prescale=0 gives tick every cycle.
  - A write to PRESCALE clears presc_cnt in the same edge.
- PWM counter:
  - pwm_cnt (8-bit) increments on tick and wraps 255->0.
  - period_end = tick && pwm_cnt==255.
- Brightness update:
  - At period_end, if pending: active_bright<=shadow_bright and pending<=0.
  - Updates happen only on period boundaries (glitch-free).
  - A BRIGHT write in the period_end cycle: the latch uses the pre-write shadow value, and pending ends at 1 (write wins over clear).
- pwm_on:
  - pwm_on = (active_bright==255) || (pwm_cnt < active_bright).
  - 0 means always off; 255 means always on.
- Blink:
  - If blink_half==0: phase held 1 and blink_cnt held 0.
  - Otherwise, at period_end blink_cnt increments. When blink_cnt==blink_half-1, blink_cnt<=0 and phase toggles.
  - A write to BLINK_HALF clears blink_cnt; phase is unchanged.
- Output:
  - led_out[i] <= led_in[i] & pwm_on & (~blink_mask[i] | phase), registered.
  - Latency is 1 clock from led_in/pwm_cnt to led_out.
- Reset asserted mid-operation:
  - All state returns to reset values on the next edge.
  - led_out=0 in the cycle after reset is sampled.
  - Pending updates are discarded.

Test Plan:
1. Reset defaults:
   - Stimulus: reset 2 cycles, led_in=8'hA5, no writes.
   - Required: led_out=8'h00 in the first cycle after reset deasserts, then 8'hA5 continuously. Read addr0 = 32'h000000FF.
2. PWM duty:
   - Stimulus: prescale=0, BRIGHT=64, led_in=8'hFF, wait for the period boundary.
   - Required: each 256-clock period shows led_out=8'hFF for exactly 64 cycles, then 8'h00 for 192. Before the boundary, addr0 reads 32'h00000140; after it, 32'h00000040.
3. Glitch-free update:
   - Stimulus: write BRIGHT=200 mid-period (pwm_cnt=100) while active=64.
   - Required: the current period still ends its high time at 64 cycles. The next period is high for 200 cycles.
4. Write on the boundary:
   - Stimulus: write BRIGHT=10 in the period_end cycle while shadow=64 and pending=1.
   - Required: the next period uses 64, pending stays 1, and the following period uses 10.
5. Blink and prescaler:
   - Stimulus: prescale=1, BRIGHT=255, BLINK_MASK=8'h0F, BLINK_HALF=2, led_in=8'hFF.
   - Required: led_out alternates 8'hFF and 8'hF0, each for 1024 clocks (2 periods × 256 ticks × 2 clocks).
   - Then write BLINK_HALF=0: led_out returns to a steady 8'hFF from the next cycle.
6. Reset mid-blink:
   - Stimulus: assert reset while phase=0 with pending=1.
   - Required: led_out=0 in the cycle after reset is sampled. After release, led_out equals led_in (brightness 255, no blink) and addr0 reads 32'h000000FF.
